// File: rtl/sync_reg8.sv
// sync_reg8: WIDTH-bit D register with synchronous active-low clear.
// q comes straight from the flops; there is no input-to-output path.
module sync_reg8 #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_sync_reg8.sv
// tb_sync_reg8: directed timeline plus randomized cycles
// checked against a simple next-value model.
`timescale 1ns/1ps
module tb_sync_reg8;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [7:0] q;

    int checks;
    int errors;

    sync_reg8 #(
        .WIDTH      (8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d  (d),
        .q  (q)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic at(input int t);
        if (t > $time) #(t - $time);
    endtask

    // Model: the value q must hold after an edge that samples (r, v).
    function automatic logic [7:0] next_q(input logic r, input logic [7:0] v);
        return r ? v : 8'h00;
    endfunction

    logic [7:0] prev;
    logic [7:0] exp;
    logic       r;
    logic [7:0] v;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        d   = 8'h01;

        at(21);  chk("release", q, 8'h01);
        at(38);  rst = 1'b0;
        at(59);  chk("clr_hold", q, 8'h01);
        at(61);  chk("clr", q, 8'h00);
        at(78);  rst = 1'b1; d = 8'h01;
        at(99);  chk("rel_hold", q, 8'h00);
        at(101); chk("rel", q, 8'h01);
        at(122); d = 8'h00;
        at(141); chk("track0", q, 8'h00);
        at(162); d = 8'h01;
        at(181); chk("track1", q, 8'h01);
        at(198); d = 8'h00;
        at(200); chk("glitch_mid", q, 8'h01);
        at(202); d = 8'h01;
        at(219); chk("glitch_pre", q, 8'h01);
        at(221); chk("glitch_post", q, 8'h01);
        at(230); d = 8'hA5; rst = 1'b1;
        at(261); chk("full_a5", q, 8'hA5);
        at(270); d = 8'h5A; rst = 1'b0;
        at(301); chk("prio_rst", q, 8'h00);
        at(310); rst = 1'b1;
        at(341); chk("full_5a", q, 8'h5A);
        at(350); d = 8'h00;
        at(361); chk("negedge", q, 8'h5A);
        at(381); chk("after_neg", q, 8'h00);
        prev = 8'h00;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = ($urandom_range(0, 3) != 0);
            v = 8'($urandom);
            rst = r;
            d = v;
            #1;
            chk("rnd_hold", q, prev);
            exp = next_q(r, v);
            if ($urandom_range(0, 3) == 0) begin
                #5 d = ~v; rst = ~r;
                #5 d = v; rst = r;
            end
            @(posedge clk);
            #1;
            chk("rnd_cap", q, exp);
            prev = exp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
